// File: rtl/passcode_controller.sv
// Keypad passcode checker: buffers entered digits, compares them one per two-cycle
// slot through an external registered comparator, and drives unlock/deny/lockout.
module passcode_controller #(
  parameter int                    CODE_LEN     = 4,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = 16'h1234,
  parameter int                    MAX_TRIES    = 3,
  parameter int                    GRANT_CYCLES = 50,
  parameter int                    LOCK_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_clear,
  input  logic       prog_en,
  output logic [3:0] cmp_a,
  output logic [3:0] cmp_b,
  output logic       cmp_en,
  input  logic       cmp_eq,
  output logic       unlock,
  output logic       deny,
  output logic       locked,
  output logic       alarm,
  output logic       busy,
  output logic [1:0] fail_count
);

  localparam int TMAX = (GRANT_CYCLES > LOCK_CYCLES) ? GRANT_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (CODE_LEN > 2) ? $clog2(CODE_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CODE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHK_ISSUE, S_CHK_READ, S_GRANT, S_DENY, S_LOCKOUT, S_PROG
  } state_t;

  // Element 0 is the first digit entered, i.e. the most significant nibble.
  typedef logic [0:CODE_LEN-1][3:0] digits_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            match_q, match_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      fail_q, fail_d;
  digits_t         entry_q, entry_d;
  digits_t         new_q, new_d;
  digits_t         code_q, code_d;
  logic [3:0]      cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
  logic            cmp_en_q, cmp_en_d, unlock_q, unlock_d, deny_q, deny_d;
  logic            locked_q, locked_d, alarm_q, alarm_d, busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    match_d = match_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    entry_d = entry_q;
    new_d   = new_q;
    code_d  = code_q;

    case (state_q)
      S_IDLE: begin
        if (key_clear) begin
          idx_d = '0;
        end else if (key_valid) begin
          entry_d[0] = key_digit;
          idx_d      = IW'(1);
          state_d    = S_ENTRY;
        end else begin
          idx_d = '0;
        end
      end
      S_ENTRY: begin
        if (key_clear) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (key_valid) begin
          entry_d[idx_q] = key_digit;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            match_d = 1'b1;
            state_d = S_CHK_ISSUE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = S_ENTRY;
        end
      end
      S_CHK_ISSUE: begin
        state_d = S_CHK_READ;
      end
      // Every slot is visited regardless of earlier mismatches so check time is constant.
      S_CHK_READ: begin
        match_d = match_q & cmp_eq;
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + IW'(1);
          state_d = S_CHK_ISSUE;
        end else if (match_d) begin
          idx_d   = '0;
          fail_d  = 2'd0;
          timer_d = TW'(GRANT_CYCLES - 1);
          state_d = S_GRANT;
        end else begin
          idx_d   = '0;
          fail_d  = fail_q + 2'd1;
          state_d = S_DENY;
        end
      end
      S_GRANT: begin
        if (prog_en) begin
          idx_d   = '0;
          state_d = S_PROG;
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DENY: begin
        if (fail_q == 2'(MAX_TRIES)) begin
          timer_d = TW'(LOCK_CYCLES - 1);
          state_d = S_LOCKOUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_d  = 2'd0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      // The stored code is only replaced once a complete new code has been keyed.
      S_PROG: begin
        if (key_clear) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (key_valid) begin
          new_d[idx_q] = key_digit;
          if (idx_q == LAST_IDX) begin
            code_d  = new_d;
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = S_PROG;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    unlock_d = (state_d == S_GRANT);
    deny_d   = (state_d == S_DENY);
    locked_d = (state_d == S_LOCKOUT);
    alarm_d  = (state_d == S_LOCKOUT);
    busy_d   = (state_d == S_CHK_ISSUE) || (state_d == S_CHK_READ) ||
               (state_d == S_GRANT) || (state_d == S_LOCKOUT);
    cmp_en_d = (state_d == S_CHK_ISSUE);
    if (cmp_en_d) begin
      cmp_a_d = entry_d[idx_d];
      cmp_b_d = code_d[idx_d];
    end else begin
      cmp_a_d = 4'h0;
      cmp_b_d = 4'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      match_q  <= 1'b0;
      timer_q  <= '0;
      fail_q   <= 2'd0;
      entry_q  <= '0;
      new_q    <= '0;
      code_q   <= DEFAULT_CODE;
      cmp_a_q  <= 4'h0;
      cmp_b_q  <= 4'h0;
      cmp_en_q <= 1'b0;
      unlock_q <= 1'b0;
      deny_q   <= 1'b0;
      locked_q <= 1'b0;
      alarm_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      match_q  <= match_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      entry_q  <= entry_d;
      new_q    <= new_d;
      code_q   <= code_d;
      cmp_a_q  <= cmp_a_d;
      cmp_b_q  <= cmp_b_d;
      cmp_en_q <= cmp_en_d;
      unlock_q <= unlock_d;
      deny_q   <= deny_d;
      locked_q <= locked_d;
      alarm_q  <= alarm_d;
      busy_q   <= busy_d;
    end
  end

  assign cmp_a      = cmp_a_q;
  assign cmp_b      = cmp_b_q;
  assign cmp_en     = cmp_en_q;
  assign unlock     = unlock_q;
  assign deny       = deny_q;
  assign locked     = locked_q;
  assign alarm      = alarm_q;
  assign busy       = busy_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_passcode_controller.sv
// Scoreboard bench for passcode_controller: directed key sequences push expected
// output events; a negedge monitor pops and compares every event the DUT shows.
module tb_passcode_controller;

  localparam int K_CMP = 0, K_URISE = 1, K_UFALL = 2, K_DENY = 3, K_LRISE = 4, K_LFALL = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'h0;
  logic       key_clear = 1'b0;
  logic       prog_en = 1'b0;
  logic [3:0] cmp_a, cmp_b;
  logic       cmp_en, cmp_eq, unlock, deny, locked, alarm, busy;
  logic [1:0] fail_count;
  logic       cmp_eq_r = 1'b0;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [15:0] cur_code = 16'h1234;
  logic       prev_unlock = 1'b0;
  logic       prev_locked = 1'b0;

  passcode_controller dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .key_clear(key_clear), .prog_en(prog_en), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_en(cmp_en), .cmp_eq(cmp_eq), .unlock(unlock), .deny(deny),
    .locked(locked), .alarm(alarm), .busy(busy), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered 4-bit comparator model: result valid the cycle after cmp_en.
  always @(posedge clk) if (cmp_en) cmp_eq_r <= (cmp_a == cmp_b);
  assign cmp_eq = cmp_eq_r;

  task automatic push(input int k, input int c, input logic [7:0] d);
    exp_t e;
    e.kind = k; e.cyc = c; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input int k, input logic [7:0] d);
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d data=%h, required no event", k, cyc, d);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || e.cyc != cyc || e.data != d) begin
        n_bad++;
        $display("FAIL event: got kind=%0d cyc=%0d data=%h, required kind=%0d cyc=%0d data=%h",
                 k, cyc, d, e.kind, e.cyc, e.data);
      end
    end
  endtask

  // Monitor: every cmp_en cycle, unlock/locked edge and deny cycle is an event.
  always @(negedge clk) begin
    if (rst) begin
      prev_unlock <= 1'b0;
      prev_locked <= 1'b0;
    end else begin
      if (cmp_en) sb_check(K_CMP, {cmp_a, cmp_b});
      if (unlock && !prev_unlock) sb_check(K_URISE, {busy, deny, locked, cmp_en, 2'b00, fail_count});
      if (!unlock && prev_unlock) sb_check(K_UFALL, {busy, deny, locked, cmp_en, 2'b00, fail_count});
      if (deny) sb_check(K_DENY, {busy, unlock, locked, alarm, 2'b00, fail_count});
      if (locked && !prev_locked) sb_check(K_LRISE, {alarm, busy, unlock, deny, 2'b00, fail_count});
      if (!locked && prev_locked) sb_check(K_LFALL, {alarm, busy, unlock, deny, 2'b00, fail_count});
      prev_unlock <= unlock;
      prev_locked <= locked;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    key_valid = 1'b1;
    key_digit = d;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d events still pending, required 0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Key in a 4-digit code and queue the expected compare slots and verdict.
  task automatic enter_code(input logic [15:0] digs, input bit ok, input logic [1:0] exp_fail,
                            input bit lock, input bit push_ufall);
    int e0;
    for (int i = 0; i < 3; i++) press(digs[15-4*i -: 4]);
    @(negedge clk);
    e0 = cyc + 1;
    for (int i = 0; i < 4; i++) push(K_CMP, e0 + 2*i, {digs[15-4*i -: 4], cur_code[15-4*i -: 4]});
    if (ok) begin
      push(K_URISE, e0 + 8, 8'h80);
      if (push_ufall) push(K_UFALL, e0 + 58, 8'h00);
    end else begin
      push(K_DENY, e0 + 8, {6'b000000, exp_fail});
      if (lock) begin
        push(K_LRISE, e0 + 9, 8'hC3);
        push(K_LFALL, e0 + 1009, 8'h00);
      end
    end
    key_valid = 1'b1;
    key_digit = digs[3:0];
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic start_prog();
    @(negedge clk);
    push(K_UFALL, cyc + 1, 8'h00);
    prog_en = 1'b1;
    @(negedge clk);
    prog_en = 1'b0;
  endtask

  task automatic reset_pulse_check(input string name);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk(name, {16'h0, unlock, deny, locked, alarm, busy, cmp_en, cmp_a, cmp_b, fail_count},
           32'h0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_asserted_outputs",
        {16'h0, unlock, deny, locked, alarm, busy, cmp_en, cmp_a, cmp_b, fail_count}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_released_outputs",
        {16'h0, unlock, deny, locked, alarm, busy, cmp_en, cmp_a, cmp_b, fail_count}, 32'h0);

    enter_code(16'h1234, 1'b1, 2'd0, 1'b0, 1'b1);
    drain(100);
    enter_code(16'h1235, 1'b0, 2'd1, 1'b0, 1'b0);
    drain(100);

    // Clear together with a strobe discards the partial entry without counting a failure.
    press(4'h1);
    press(4'h2);
    @(negedge clk);
    key_valid = 1'b1; key_clear = 1'b1; key_digit = 4'h3;
    @(negedge clk);
    key_valid = 1'b0; key_clear = 1'b0;
    enter_code(16'h1111, 1'b0, 2'd2, 1'b0, 1'b0);
    drain(100);
    enter_code(16'h1234, 1'b1, 2'd0, 1'b0, 1'b1);
    drain(100);

    enter_code(16'h0000, 1'b0, 2'd1, 1'b0, 1'b0);
    drain(100);
    enter_code(16'h4321, 1'b0, 2'd2, 1'b0, 1'b0);
    drain(100);
    enter_code(16'h1233, 1'b0, 2'd3, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 4; i++) press(4'(i));
    @(negedge clk);
    prog_en = 1'b1; key_clear = 1'b1;
    @(negedge clk);
    prog_en = 1'b0; key_clear = 1'b0;
    drain(1200);
    enter_code(16'h1234, 1'b1, 2'd0, 1'b0, 1'b1);
    drain(100);

    enter_code(16'h1234, 1'b1, 2'd0, 1'b0, 1'b0);
    drain(100);
    start_prog();
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    drain(50);
    cur_code = 16'h9876;
    enter_code(16'h1234, 1'b0, 2'd1, 1'b0, 1'b0);
    drain(100);
    enter_code(16'h9876, 1'b1, 2'd0, 1'b0, 1'b0);
    drain(100);

    start_prog();
    press(4'h1); press(4'h1);
    @(negedge clk);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    drain(50);
    enter_code(16'h9876, 1'b1, 2'd0, 1'b0, 1'b0);
    drain(100);

    start_prog();
    press(4'h5); press(4'h5);
    drain(50);
    reset_pulse_check("reset_mid_prog_outputs");
    cur_code = 16'h1234;
    enter_code(16'h1234, 1'b1, 2'd0, 1'b0, 1'b1);
    drain(100);

    enter_code(16'h0000, 1'b0, 2'd1, 1'b0, 1'b0);
    drain(100);
    enter_code(16'h0000, 1'b0, 2'd2, 1'b0, 1'b0);
    drain(100);
    enter_code(16'h0000, 1'b0, 2'd3, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    chk("lockout_pending_events", 32'(sbq.size()), 32'd1);
    chk("lockout_locked_alarm", {30'h0, locked, alarm}, 32'h3);
    reset_pulse_check("reset_mid_lockout_outputs");
    enter_code(16'h9876, 1'b0, 2'd1, 1'b0, 1'b0);
    drain(100);
    enter_code(16'h1234, 1'b1, 2'd0, 1'b0, 1'b1);
    drain(100);

    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/passcode_controller.md
# passcode_controller

Sequences the registered 4-bit magnitude comparator to check a multi-digit keypad passcode against a stored code. Digits are buffered, then compared one per two-cycle slot. The block drives unlock, deny, lockout and alarm for the home-security front end. It also owns the stored code, which can be reprogrammed only while unlocked.

## Interface
- CODE_LEN, 4: digits per passcode (2..8)
- DEFAULT_CODE, 16'h1234: reset code, CODE_LEN*4 bits; digit 0 (first entered) is the MS nibble
- MAX_TRIES, 3: consecutive failures that trigger lockout (1..3)
- GRANT_CYCLES, 50: unlock pulse length in cycles (>=1)
- LOCK_CYCLES, 1000: lockout length in cycles (>=1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe, key_digit valid
- key_digit  in  4  entered digit
- key_clear  in  1  discard the current entry or programming
- prog_en  in  1  request to program a new code, honoured only in GRANT
- cmp_a  out  4  entered digit to comparator A
- cmp_b  out  4  stored digit to comparator B
- cmp_en  out  1  comparator register load enable
- cmp_eq  in  1  comparator A_equal_B, valid the cycle after cmp_en
- unlock  out  1  high during GRANT
- deny  out  1  one-cycle pulse on a failed check
- locked  out  1  high during LOCKOUT
- alarm  out  1  high during LOCKOUT
- busy  out  1  high in CHK_ISSUE, CHK_READ, GRANT, LOCKOUT
- fail_count  out  2  consecutive failures so far

## Operation
- States: IDLE, ENTRY, CHK_ISSUE, CHK_READ, GRANT, DENY, LOCKOUT, PROG.
- IDLE: key_valid stores digit 0, sets idx=1 and moves to ENTRY.
- ENTRY: each key_valid stores entry[idx] and increments idx.
  - The strobe that fills digit CODE_LEN-1 moves to CHK_ISSUE with idx=0 and match=1.
  - key_clear returns to IDLE. The entry is discarded and no failure is counted.
- CHK_ISSUE: cmp_a=entry[idx], cmp_b=code[idx], cmp_en=1. Next state is CHK_READ.
- CHK_READ: match <= match & cmp_eq. cmp_en=0.
  - If idx<CODE_LEN-1: idx++ and go to CHK_ISSUE.
  - Otherwise go to GRANT if the final match is 1, else DENY.
  - All digits are always compared (no early exit), so check time is constant.
- GRANT: fail_count cleared; unlock held for GRANT_CYCLES, then IDLE.
  - prog_en in any GRANT cycle moves to PROG and deasserts unlock.
- PROG: key_valid digits fill new[idx].
  - After CODE_LEN digits, code <= new and go to IDLE.
  - key_clear aborts to IDLE with the old code retained.
- DENY: one cycle with deny=1 and fail_count++.
  - If the new count equals MAX_TRIES, go to LOCKOUT; else go to IDLE.
- LOCKOUT: locked=alarm=1 for LOCK_CYCLES. On exit, fail_count cleared and state goes to IDLE.
- key_valid, key_clear and prog_en are ignored in CHK_*, GRANT (except prog_en), DENY and LOCKOUT.
- If key_valid and key_clear arrive in the same cycle, key_clear wins.
- cmp_a, cmp_b and cmp_en are 0 outside CHK_ISSUE.

## Timing
- Reset values:
  - Outputs: state IDLE; unlock, deny, locked, alarm, busy, cmp_en = 0; cmp_a = cmp_b = 0; fail_count = 0.
  - Internal: code = DEFAULT_CODE; entry, idx, match, timers cleared.
- Reset mid-operation aborts immediately, including during LOCKOUT or PROG. A partially programmed code is never written.
- Outputs are Moore: decoded from registered state, no input-to-output combinational path.
- Check latency: let the last digit's key_valid be sampled at edge E0.
  - CHK_ISSUE cycles follow E0, E2, …, E(2·CODE_LEN−2).
  - The state is GRANT or DENY after edge E(2·CODE_LEN). For CODE_LEN=4, that is unlock or deny 8 cycles after E0.
- unlock is high for exactly GRANT_CYCLES cycles, unless cut short by prog_en.
- deny is high for exactly 1 cycle.
- locked and alarm are high for exactly LOCK_CYCLES cycles.
- The timer counter is wide enough for max(GRANT_CYCLES, LOCK_CYCLES). It loads on state entry and does not wrap.

## Test plan
- Reset, then enter digits 1,2,3,4 -> cmp_en pulses at E0+1, +3, +5, +7; unlock rises 8 cycles after E0 and stays high 50 cycles; fail_count=0.
- Enter 1,2,3,5 -> all 4 slots compared; deny pulses once; fail_count=1; unlock stays 0.
- Three wrong codes in a row -> third deny is followed by locked=alarm=1 for 1000 cycles; keys are ignored during lockout; fail_count=0 afterwards; code 1234 then unlocks.
- Enter 1,2, then key_clear together with key_valid -> IDLE, fail_count unchanged; then 1,2,3,4 unlocks.
- Unlock, assert prog_en, enter 9,8,7,6 -> 1234 now denies and 9876 unlocks; a separate PROG aborted by key_clear leaves the code unchanged.
- Assert rst mid-LOCKOUT and mid-PROG -> all outputs 0 immediately; code reverts to 1234.
